// File: rtl/laser_pkg.sv
// Shared types and default constants for the laser echo receiver.
package laser_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  localparam int unsigned DEF_CNT_W          = 32;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 2000000;
  localparam int unsigned ECHO_COUNT_W       = 16;

endpackage

// File: rtl/laser_echo_sync_filter.sv
// Echo input conditioning: 2-flop synchroniser, optional glitch filter, edge detector.
// Optional glitch filter enabled by defining LASER_ECHO_GLITCH_FILTER_EN.
module laser_echo_sync_filter #(
  parameter int unsigned FILTER_LEN = 4
) (
  input  logic clock,
  input  logic reset_n,
  input  logic echo_in,
  output logic rise,
  output logic fall
);

`ifdef LASER_ECHO_GLITCH_FILTER_EN
  localparam bit USE_FILTER = 1'b1;
`else
  localparam bit USE_FILTER = 1'b0;
`endif

  logic sync1;
  logic sync2;
  logic level;
  logic prev;

  // Two-stage synchroniser for the asynchronous comparator output.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= echo_in;
      sync2 <= sync1;
    end
  end

  generate
    if (USE_FILTER && (FILTER_LEN > 0)) begin : g_filter
      localparam int unsigned RUN_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
      logic [RUN_W-1:0] run_cnt;
      logic             filt;

      // Level follows the synchroniser only after FILTER_LEN consecutive differing samples.
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          run_cnt <= '0;
          filt    <= 1'b0;
        end else if (sync2 == filt) begin
          run_cnt <= '0;
        end else if (run_cnt == RUN_W'(FILTER_LEN - 1)) begin
          run_cnt <= '0;
          filt    <= sync2;
        end else begin
          run_cnt <= run_cnt + RUN_W'(1);
        end
      end

      assign level = filt;
    end else begin : g_raw
      assign level = sync2;
    end
  endgenerate

  // Previous-sample flop for edge detection.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prev <= 1'b0;
    end else begin
      prev <= level;
    end
  end

  assign rise = level & ~prev;
  assign fall = ~level & prev;

endmodule

// File: rtl/laser_echo_measure.sv
// Echo high-time / period measurement with lost-train timeout.
// Optional glitch filter enabled by defining LASER_ECHO_GLITCH_FILTER_EN.
module laser_echo_measure
  import laser_pkg::*;
#(
  parameter int unsigned CNT_W          = DEF_CNT_W,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int unsigned FILTER_LEN     = 4
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic                    echo_in,
  output logic [CNT_W-1:0]        width_out,
  output logic [CNT_W-1:0]        period_out,
  output logic                    meas_valid,
  output logic                    timeout,
  output logic [ECHO_COUNT_W-1:0] echo_count
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT_CYCLES);

  state_t           state, state_d;
  logic [CNT_W-1:0] width_cnt, width_d;
  logic [CNT_W-1:0] per_cnt, per_d;
  logic [CNT_W-1:0] width_inc, per_inc;
  logic             rise, fall;
  logic             capture, set_to, clr_to;

  laser_echo_sync_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_sync (
    .clock  (clock),
    .reset_n(reset_n),
    .echo_in(echo_in),
    .rise   (rise),
    .fall   (fall)
  );

  assign width_inc = (width_cnt == '1) ? width_cnt : width_cnt + ONE;
  assign per_inc   = (per_cnt == '1) ? per_cnt : per_cnt + ONE;

  // Next-state and counter update; a closing rise takes priority over timeout in LOW.
  always_comb begin
    state_d = state;
    width_d = width_cnt;
    per_d   = per_cnt;
    capture = 1'b0;
    set_to  = 1'b0;
    clr_to  = 1'b0;
    if (!enable) begin
      state_d = IDLE;
      width_d = '0;
      per_d   = '0;
      clr_to  = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (rise) begin
            state_d = HIGH;
            width_d = ONE;
            per_d   = ONE;
          end
        end
        HIGH: begin
          if (per_cnt >= TMO) begin
            state_d = IDLE;
            set_to  = 1'b1;
            width_d = '0;
            per_d   = '0;
          end else begin
            per_d = per_inc;
            if (fall) begin
              state_d = LOW;
            end else begin
              width_d = width_inc;
            end
          end
        end
        LOW: begin
          if (rise) begin
            capture = 1'b1;
            state_d = HIGH;
            width_d = ONE;
            per_d   = ONE;
          end else if (per_cnt >= TMO) begin
            state_d = IDLE;
            set_to  = 1'b1;
            width_d = '0;
            per_d   = '0;
          end else begin
            per_d = per_inc;
          end
        end
        default: begin
          state_d = IDLE;
          width_d = '0;
          per_d   = '0;
        end
      endcase
    end
  end

  // State, counters and published results.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      width_cnt  <= '0;
      per_cnt    <= '0;
      width_out  <= '0;
      period_out <= '0;
      meas_valid <= 1'b0;
      timeout    <= 1'b0;
      echo_count <= '0;
    end else begin
      state      <= state_d;
      width_cnt  <= width_d;
      per_cnt    <= per_d;
      meas_valid <= capture;
      if (capture) begin
        width_out  <= width_cnt;
        period_out <= per_cnt;
        echo_count <= echo_count + ECHO_COUNT_W'(1);
      end
      if (set_to) begin
        timeout <= 1'b1;
      end else if (capture || clr_to) begin
        timeout <= 1'b0;
      end
    end
  end

endmodule
